// File: rtl/dtfm_pkg.sv
// Shared state encoding, sizing defaults and marker words for the DTFM serial front end.
// DTFM_MARKER_EN: when defined, the MARKER state and marker constants are compiled in.
package dtfm_pkg;
    localparam int GROUP_BITS_DEF = 2816;
    localparam int GROUPS_DEF     = 4;

`ifdef DTFM_MARKER_EN
    localparam int          MARKER_BITS = 44;
    localparam logic [30:0] M = 31'b1111100110100100001010111011000;
    localparam logic [12:0] B = 13'b1111100110101;

    typedef enum logic [1:0] {WAIT_SYNC, MARKER, DATA} state_t;

    // Odd groups invert M, groups 2 and 3 invert B.
    function automatic logic [MARKER_BITS-1:0] mark_word(input logic [1:0] n);
        return {n[0] ? ~M : M, n[1] ? ~B : B};
    endfunction
`else
    typedef enum logic [1:0] {WAIT_SYNC, DATA = 2'd2} state_t;
`endif
endpackage

// File: rtl/dtfm_edge_sync.sv
// Three-flop synchronizer for an asynchronous line, with rise/fall strobes from the settled taps.
module dtfm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [2:0] s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s <= '0;
        else      s <= {s[1:0], din};
    end

    assign rise = !s[2] &  s[1];
    assign fall =  s[2] & !s[1];
endmodule

// File: rtl/dtfm_marker_writer.sv
// DTFM capture front end: syncs dCLK/dFM/dDAT and emits the per-group marker + data bit stream.
// DTFM_MARKER_EN: enables marker emission and the one-entry hold register.
module dtfm_marker_writer
    import dtfm_pkg::*;
#(
    parameter int GROUP_BITS = GROUP_BITS_DEF,
    parameter int GROUPS     = GROUPS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dCLK,
    input  logic       dFM,
    input  logic       dDAT,
    input  logic       bufFull,
    output logic       bitData,
    output logic       bitWrite,
    output logic       frameActive,
    output logic [1:0] groupNum,
    output logic       ovf,
    output logic [7:0] resyncCount
);
    localparam int            CW       = $clog2(GROUP_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(GROUP_BITS);
    localparam logic [1:0]    GRP_LAST = 2'(GROUPS - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    grp_n;
    logic [7:0]    rsc_n;
    logic          bit_n, wr_n, ovf_n, due, due_bit;
    logic          sync_front, clk_rear, unused_fm_fall, unused_clk_rise, unused_dat;
    logic [2:0]    dsync;

`ifdef DTFM_MARKER_EN
    localparam logic [MARKER_BITS-1:0] MARK0 = mark_word(2'd0);
    logic [5:0]             ptr, ptr_n;
    logic                   pend, pend_n, hold, hold_n;
    logic [MARKER_BITS-1:0] mk;
    assign mk = mark_word(groupNum);
`endif

    dtfm_edge_sync u_fm  (.clk(clk), .rst(rst), .din(dFM),  .rise(sync_front),      .fall(unused_fm_fall));
    dtfm_edge_sync u_clk (.clk(clk), .rst(rst), .din(dCLK), .rise(unused_clk_rise), .fall(clk_rear));

    assign unused_dat  = dsync[2];
    assign frameActive = (state != WAIT_SYNC);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grp_n   = groupNum;
        rsc_n   = resyncCount;
        ovf_n   = ovf;
        due     = 1'b0;
        due_bit = 1'b0;
        wr_n    = 1'b0;
        bit_n   = 1'b0;
`ifdef DTFM_MARKER_EN
        ptr_n   = ptr;
        pend_n  = pend;
        hold_n  = hold;
`endif
        if (sync_front) begin
            if (state != WAIT_SYNC && resyncCount != 8'hFF) rsc_n = resyncCount + 8'd1;
            grp_n = '0;
            cnt_n = '0;
`ifdef DTFM_MARKER_EN
            // Marker bit 43 goes out with this edge; MARKER continues from bit 42.
            state_n = MARKER;
            ptr_n   = 6'(MARKER_BITS - 2);
            pend_n  = 1'b0;
            due     = 1'b1;
            due_bit = MARK0[MARKER_BITS-1];
`else
            state_n = DATA;
`endif
        end else begin
            case (state)
`ifdef DTFM_MARKER_EN
                MARKER: begin
                    due     = 1'b1;
                    due_bit = mk[ptr];
                    if (ptr == '0) state_n = DATA;
                    else           ptr_n   = ptr - 6'd1;
                    if (clk_rear) begin
                        if (pend) ovf_n = 1'b1;
                        else begin
                            pend_n = 1'b1;
                            hold_n = dsync[1];
                        end
                    end
                end
`endif
                DATA: begin
`ifdef DTFM_MARKER_EN
                    // A bit parked during the marker drains first; a coincident edge refills the hold.
                    if (pend) begin
                        due     = 1'b1;
                        due_bit = hold;
                        pend_n  = clk_rear;
                        hold_n  = dsync[1];
                    end else
`endif
                    if (clk_rear) begin
                        due     = 1'b1;
                        due_bit = dsync[1];
                    end
                    if (due) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == CNT_LAST) begin
                            cnt_n = '0;
                            if (groupNum == GRP_LAST) state_n = WAIT_SYNC;
                            else begin
                                grp_n = groupNum + 2'd1;
`ifdef DTFM_MARKER_EN
                                state_n = MARKER;
                                ptr_n   = 6'(MARKER_BITS - 1);
`endif
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        // A full FIFO swallows the bit but the stream position still advances.
        if (due) begin
            if (bufFull) ovf_n = 1'b1;
            else begin
                wr_n  = 1'b1;
                bit_n = due_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= WAIT_SYNC;
            cnt         <= '0;
            groupNum    <= '0;
            resyncCount <= '0;
            ovf         <= 1'b0;
            bitWrite    <= 1'b0;
            bitData     <= 1'b0;
            dsync       <= '0;
`ifdef DTFM_MARKER_EN
            ptr         <= '0;
            pend        <= 1'b0;
            hold        <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            groupNum    <= grp_n;
            resyncCount <= rsc_n;
            ovf         <= ovf_n;
            bitWrite    <= wr_n;
            bitData     <= bit_n;
            dsync       <= {dsync[1:0], dDAT};
`ifdef DTFM_MARKER_EN
            ptr         <= ptr_n;
            pend        <= pend_n;
            hold        <= hold_n;
`endif
        end
    end
endmodule
